// File: rtl/bsg_profiler_sum_channels.sv
// Per-channel profiling accumulators with atomic snapshot-and-clear, streamed out one channel per beat.
// Latency: increments land 1 cycle later; a dump accepted at edge t shows v_o from t+1 and holds each beat until yumi_i.
// Backpressure: dump_v_i is ignored while streaming. Build with BSG_PROFILER_SUM_CHANNELS_SATURATE_EN to saturate instead of wrap.
module bsg_profiler_sum_channels #(
   parameter int els_p       = 32,
   parameter int width_p     = 16,
   parameter int sum_width_p = 32,
   localparam int lg_els_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [els_p*width_p-1:0]   countme_i,
   input  logic                       clear_i,
   input  logic                       dump_v_i,
   output logic                       dump_ready_o,
   output logic                       v_o,
   output logic [sum_width_p-1:0]     data_o,
   output logic                       overflow_o,
   output logic [lg_els_lp-1:0]       id_o,
   input  logic                       yumi_i
);

   typedef enum logic {IDLE, SEND} state_e;

   localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1);

   state_e                 state_r;
   logic [lg_els_lp-1:0]   idx_r;
   logic [sum_width_p-1:0] acc_r  [els_p];
   logic [sum_width_p-1:0] snap_r [els_p];
   logic [els_p-1:0]       ovf_r;
   logic [els_p-1:0]       snap_ovf_r;

   logic [sum_width_p-1:0] inc      [els_p];
   logic [sum_width_p-1:0] acc_next [els_p];
   logic [els_p-1:0]       carry;
   logic                   dump_fire;

   assign dump_fire = (state_r == IDLE) && dump_v_i;

   always_comb begin
      for (int i = 0; i < els_p; i++) begin
         inc[i] = sum_width_p'(countme_i[i*width_p +: width_p]);
         {carry[i], acc_next[i]} = {1'b0, acc_r[i]} + {1'b0, inc[i]};
`ifdef BSG_PROFILER_SUM_CHANNELS_SATURATE_EN
         if (carry[i]) acc_next[i] = '1;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         idx_r   <= '0;
         for (int i = 0; i < els_p; i++) begin
            acc_r[i]      <= '0;
            snap_r[i]     <= '0;
            ovf_r[i]      <= 1'b0;
            snap_ovf_r[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < els_p; i++) begin
            // The snapshot takes the pre-add value, so this cycle's increment seeds the fresh count.
            if (clear_i) begin
               acc_r[i] <= '0;
               ovf_r[i] <= 1'b0;
            end else if (dump_fire) begin
               acc_r[i] <= inc[i];
               ovf_r[i] <= 1'b0;
            end else begin
               acc_r[i] <= acc_next[i];
               ovf_r[i] <= ovf_r[i] | carry[i];
            end
            if (dump_fire) begin
               snap_r[i]     <= acc_r[i];
               snap_ovf_r[i] <= ovf_r[i];
            end
         end

         case (state_r)
            IDLE: begin
               if (dump_v_i) begin
                  state_r <= SEND;
                  idx_r   <= '0;
               end
            end
            SEND: begin
               if (yumi_i) begin
                  if (idx_r == last_idx_lp) begin
                     state_r <= IDLE;
                     idx_r   <= '0;
                  end else begin
                     idx_r <= idx_r + 1'b1;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign dump_ready_o = (state_r == IDLE);
   assign v_o          = (state_r == SEND);
   assign data_o       = snap_r[idx_r];
   assign overflow_o   = snap_ovf_r[idx_r];
   assign id_o         = idx_r;

endmodule

// File: tb/tb_bsg_profiler_sum_channels.sv
// Scoreboard bench for bsg_profiler_sum_channels: a behavioural model queues expected beats at each accepted dump.
module tb_bsg_profiler_sum_channels;

   localparam int ELS = 4;
   localparam int W   = 8;
   localparam int SW  = 8;

   logic            clk = 1'b0;
   logic            reset_i;
   logic [ELS*W-1:0] countme_i;
   logic            clear_i;
   logic            dump_v_i;
   logic            dump_ready_o;
   logic            v_o;
   logic [SW-1:0]   data_o;
   logic            overflow_o;
   logic [1:0]      id_o;
   logic            yumi_i;

   bsg_profiler_sum_channels #(.els_p(ELS), .width_p(W), .sum_width_p(SW)) dut (
      .clk_i(clk), .reset_i(reset_i), .countme_i(countme_i), .clear_i(clear_i),
      .dump_v_i(dump_v_i), .dump_ready_o(dump_ready_o), .v_o(v_o), .data_o(data_o),
      .overflow_o(overflow_o), .id_o(id_o), .yumi_i(yumi_i)
   );

   always #5 clk = ~clk;

   typedef struct {int id; int data; bit ovf;} beat_t;
   beat_t sb[$];

   int  n_checks = 0;
   int  n_errors = 0;
   int  cm [ELS];
   int  m_acc [ELS];
   bit  m_ovf [ELS];
   bit  m_send = 0;
   int  m_left = 0;
   bit  r_reset, r_clear, r_dump, r_yumi;
   bit  chk_en = 0;
   bit  acct_en = 0;
   int  acct_sum = 0;
   int  ones_cycles = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_step();
      bit old_send;
      bit fire;
      int sum;
      old_send = m_send;
      if (r_reset) begin
         for (int i = 0; i < ELS; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
         end
         m_send = 0;
         m_left = 0;
         sb.delete();
         return;
      end
      fire = !old_send && r_dump;
      if (fire)
         for (int i = 0; i < ELS; i++) sb.push_back('{i, m_acc[i], m_ovf[i]});
      for (int i = 0; i < ELS; i++) begin
         sum = m_acc[i] + cm[i];
         if (r_clear) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
         end else if (fire) begin
            m_acc[i] = cm[i];
            m_ovf[i] = 0;
         end else begin
            if (sum > 255) begin
               m_ovf[i] = 1;
`ifdef BSG_PROFILER_SUM_CHANNELS_SATURATE_EN
               sum = 255;
`else
               sum = sum - 256;
`endif
            end
            m_acc[i] = sum;
         end
      end
      if (fire) begin
         m_send = 1;
         m_left = ELS;
      end else if (old_send && yumi_i) begin
         m_left--;
         if (m_left == 0) m_send = 0;
      end
   endtask

   // Called at the falling edge: drive inputs, check current outputs, advance the model, cross one rising edge.
   task automatic cycle();
      beat_t e;
      reset_i  = r_reset;
      clear_i  = r_clear;
      dump_v_i = r_dump;
      yumi_i   = r_yumi & m_send;
      for (int i = 0; i < ELS; i++) countme_i[i*W +: W] = 8'(cm[i]);
      if (chk_en) begin
         check("v_o", v_o, m_send);
         check("dump_ready", dump_ready_o, !m_send);
         if (m_send) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sb[0];
               check("beat_id", id_o, e.id);
               check("beat_data", data_o, e.data);
               check("beat_ovf", overflow_o, e.ovf);
               if (yumi_i) begin
                  void'(sb.pop_front());
                  if (acct_en && e.id == 0) acct_sum += data_o;
               end
            end
         end
      end
      if (acct_en && !r_clear) ones_cycles += cm[0];
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int budget = 200;
      while (m_send && budget > 0) begin
         cycle();
         budget--;
      end
      if (m_send) check("drain_timeout", 1, 0);
   endtask

   task automatic set_cm(input int v);
      for (int i = 0; i < ELS; i++) cm[i] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      r_reset = 1; r_clear = 0; r_dump = 0; r_yumi = 0;
      set_cm(0);
      for (int i = 0; i < ELS; i++) begin
         m_acc[i] = 0;
         m_ovf[i] = 0;
      end
      @(negedge clk);
      repeat (2) cycle();
      r_reset = 0;
      chk_en = 1;
      check("rst_v", v_o, 0);
      check("rst_ready", dump_ready_o, 1);
      check("rst_data", data_o, 0);
      check("rst_ovf", overflow_o, 0);
      check("rst_id", id_o, 0);

      // Basic readout: channel i gets i+1 for 10 cycles.
      for (int i = 0; i < ELS; i++) cm[i] = i + 1;
      repeat (10) cycle();
      set_cm(0);
      r_dump = 1; r_yumi = 1;
      cycle();
      r_dump = 0;
      drain();
      cycle();

      // Atomic snapshot: back-to-back dumps at the minimum period.
      r_clear = 1; cycle(); r_clear = 0;
      acct_en = 1;
      set_cm(1);
      r_dump = 1;
      repeat (250) cycle();
      set_cm(0);
      cycle();
      r_dump = 0;
      drain();
      acct_en = 0;
      check("atomic_total", acct_sum, ones_cycles);

      // Clear together with dump.
      r_clear = 1; cycle(); r_clear = 0;
      set_cm(1);
      repeat (100) cycle();
      r_clear = 1; r_dump = 1;
      cycle();
      r_clear = 0; r_dump = 0;
      repeat (7) cycle();
      set_cm(0);
      r_dump = 1; cycle(); r_dump = 0;
      drain();

      // Backpressure with dump held high.
      r_dump = 1;
      for (int c = 0; c < 300; c++) begin
         r_yumi = ($urandom_range(0, 9) < 3);
         for (int i = 0; i < ELS; i++) cm[i] = $urandom_range(0, 30);
         cycle();
      end
      r_dump = 0; r_yumi = 1;
      set_cm(0);
      drain();

      // Overflow: 200+100 on channel 0, 255+1 on channel 3.
      r_clear = 1; cycle(); r_clear = 0;
      cm[0] = 200; cm[1] = 10; cm[2] = 0; cm[3] = 255;
      cycle();
      cm[0] = 100; cm[1] = 10; cm[2] = 0; cm[3] = 1;
      cycle();
      set_cm(0);
      r_dump = 1; cycle(); r_dump = 0;
      drain();
      r_dump = 1; cycle(); r_dump = 0;
      drain();

      // Reset while beat 2 is on the bus.
      set_cm(5);
      repeat (3) cycle();
      set_cm(0);
      r_dump = 1; cycle(); r_dump = 0;
      cycle();
      cycle();
      check("mid_id_before_reset", id_o, 2);
      r_reset = 1; cycle(); r_reset = 0;
      check("mid_rst_v", v_o, 0);
      check("mid_rst_ready", dump_ready_o, 1);
      r_dump = 1; cycle(); r_dump = 0;
      drain();
      cycle();

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
